// File: rtl/user_module_341178296293130834_pkg.sv
// Shared opcode encodings and io_out bit positions for the 1-bit ICU.
package user_module_341178296293130834_pkg;

  typedef enum logic [3:0] {
    OP_NOP0 = 4'h0,
    OP_LD   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_ONE  = 4'h4,
    OP_NAND = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } op_e;

  localparam int unsigned B_RR   = 0;
  localparam int unsigned B_DATA = 1;
  localparam int unsigned B_WRT  = 2;
  localparam int unsigned B_JMP  = 3;
  localparam int unsigned B_RTN  = 4;
  localparam int unsigned B_FLG0 = 5;
  localparam int unsigned B_FLGF = 6;
  localparam int unsigned B_CAR  = 7;

endpackage

// File: rtl/user_module_341178296293130834_alu.sv
// Combinational 1-bit ALU: next result register and carry for the current opcode.
module ue_alu
  import user_module_341178296293130834_pkg::*;
(
  input  op_e  op,
  input  logic rr,
  input  logic d,
  input  logic car,
  output logic rr_next,
  output logic car_next
);

  logic [1:0] sum_s;

  // Result/carry update; non-ALU opcodes pass the current values through.
  always_comb begin
    sum_s    = 2'b00;
    rr_next  = rr;
    car_next = car;
    case (op)
      OP_LD:   rr_next = d;
      OP_ADD: begin
        sum_s    = {1'b0, rr} + {1'b0, d} + {1'b0, car};
        rr_next  = sum_s[0];
        car_next = sum_s[1];
      end
      // Subtract as add of the inverted operand; carry set means no borrow.
      OP_SUB: begin
        sum_s    = {1'b0, rr} + {1'b0, ~d} + {1'b0, car};
        rr_next  = sum_s[0];
        car_next = sum_s[1];
      end
      OP_ONE: begin
        rr_next  = 1'b1;
        car_next = 1'b1;
      end
      OP_NAND: rr_next = ~(rr & d);
      OP_OR:   rr_next = rr | d;
      OP_XOR:  rr_next = rr ^ d;
      default: begin
        rr_next  = rr;
        car_next = car;
      end
    endcase
  end

endmodule

// File: rtl/user_module_341178296293130834.sv
// 1-bit industrial control unit: sequencer, enables, skip logic and registered status outputs.
module user_module_341178296293130834
  import user_module_341178296293130834_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic clk;
  logic rst;
  logic d_in;
  op_e  op;
  logic unused_s;

  assign clk      = io_in[0];
  assign rst      = io_in[1];
  assign op       = op_e'(io_in[5:2]);
  assign d_in     = io_in[6];
  assign unused_s = io_in[7];

  logic rr_q, rr_d, car_q, car_d, ien_q, ien_d, oen_q, oen_d;
  logic skip_q, skip_d, data_q, data_d;
  logic wrt_q, wrt_d, jmp_q, jmp_d, rtn_q, rtn_d;
  logic flg0_q, flg0_d, flgf_q, flgf_d;
  logic gated_d_s, alu_rr_s, alu_car_s;

  assign gated_d_s = d_in & ien_q;

  ue_alu u_alu (
    .op       (op),
    .rr       (rr_q),
    .d        (gated_d_s),
    .car      (car_q),
    .rr_next  (alu_rr_s),
    .car_next (alu_car_s)
  );

  // Next-state decode; a pending skip swallows the whole instruction.
  always_comb begin
    rr_d   = rr_q;
    car_d  = car_q;
    ien_d  = ien_q;
    oen_d  = oen_q;
    skip_d = skip_q;
    data_d = data_q;
    wrt_d  = 1'b0;
    jmp_d  = 1'b0;
    rtn_d  = 1'b0;
    flg0_d = 1'b0;
    flgf_d = 1'b0;
    if (skip_q) begin
      skip_d = 1'b0;
    end else begin
      rr_d  = alu_rr_s;
      car_d = alu_car_s;
      case (op)
        OP_STO: begin
          if (oen_q) begin
            data_d = rr_q;
            wrt_d  = 1'b1;
          end else begin
            data_d = data_q;
          end
        end
        OP_STOC: begin
          if (oen_q) begin
            data_d = ~rr_q;
            wrt_d  = 1'b1;
          end else begin
            data_d = data_q;
          end
        end
        OP_IEN:  ien_d  = d_in;
        OP_OEN:  oen_d  = d_in;
        OP_JMP:  jmp_d  = 1'b1;
        OP_RTN: begin
          rtn_d  = 1'b1;
          skip_d = 1'b1;
        end
        OP_SKZ: begin
          if (!rr_q) begin
            skip_d = 1'b1;
          end else begin
            skip_d = 1'b0;
          end
        end
        OP_NOP0: flg0_d = 1'b1;
        OP_NOPF: flgf_d = 1'b1;
        default: skip_d = 1'b0;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= 1'b0;
      car_q  <= 1'b0;
      ien_q  <= 1'b0;
      oen_q  <= 1'b0;
      skip_q <= 1'b0;
      data_q <= 1'b0;
      wrt_q  <= 1'b0;
      jmp_q  <= 1'b0;
      rtn_q  <= 1'b0;
      flg0_q <= 1'b0;
      flgf_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      car_q  <= car_d;
      ien_q  <= ien_d;
      oen_q  <= oen_d;
      skip_q <= skip_d;
      data_q <= data_d;
      wrt_q  <= wrt_d;
      jmp_q  <= jmp_d;
      rtn_q  <= rtn_d;
      flg0_q <= flg0_d;
      flgf_q <= flgf_d;
    end
  end

  // Status byte assembly.
  always_comb begin
    io_out         = 8'h00;
    io_out[B_RR]   = rr_q;
    io_out[B_DATA] = data_q;
    io_out[B_WRT]  = wrt_q;
    io_out[B_JMP]  = jmp_q;
    io_out[B_RTN]  = rtn_q;
    io_out[B_FLG0] = flg0_q;
    io_out[B_FLGF] = flgf_q;
    io_out[B_CAR]  = car_q;
  end

endmodule

// File: tb/tb_user_module_341178296293130834.sv
// Scoreboard bench for the 1-bit ICU: a behavioural model queues expected status bytes.
module tb_user_module_341178296293130834;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opc = 4'h0;
  logic       d_in = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];
  logic m_rr, m_car, m_ien, m_oen, m_skip, m_data;

  assign io_in = {1'b0, d_in, opc, rst, clk};

  user_module_341178296293130834 dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial forever #5 clk = ~clk;

  // Reference behaviour of one clock edge; returns the expected status byte.
  task automatic model(input logic r, input logic [3:0] op, input logic din, output logic [7:0] e);
    logic d;
    int   s;
    logic wrt, jmp, rtn, f0, ff;
    wrt = 1'b0; jmp = 1'b0; rtn = 1'b0; f0 = 1'b0; ff = 1'b0;
    if (r) begin
      m_rr = 1'b0; m_car = 1'b0; m_ien = 1'b0; m_oen = 1'b0; m_skip = 1'b0; m_data = 1'b0;
    end else if (m_skip) begin
      m_skip = 1'b0;
    end else begin
      d = din & m_ien;
      case (op)
        4'h0: f0 = 1'b1;
        4'h1: m_rr = d;
        4'h2: begin s = m_rr + d + m_car; m_rr = s[0]; m_car = s[1]; end
        4'h3: begin s = m_rr + (d ? 0 : 1) + m_car; m_rr = s[0]; m_car = s[1]; end
        4'h4: begin m_rr = 1'b1; m_car = 1'b1; end
        4'h5: m_rr = !(m_rr && d);
        4'h6: m_rr = m_rr || d;
        4'h7: m_rr = (m_rr != d);
        4'h8: if (m_oen) begin m_data = m_rr; wrt = 1'b1; end
        4'h9: if (m_oen) begin m_data = !m_rr; wrt = 1'b1; end
        4'hA: m_ien = din;
        4'hB: m_oen = din;
        4'hC: jmp = 1'b1;
        4'hD: begin rtn = 1'b1; m_skip = 1'b1; end
        4'hE: if (!m_rr) m_skip = 1'b1;
        default: ff = 1'b1;
      endcase
    end
    e = {m_car, ff, f0, rtn, jmp, wrt, m_data, m_rr};
  endtask

  // Drive one instruction, queue its expected effect, and step past the edge.
  task automatic issue(input logic r, input logic [3:0] op, input logic din);
    logic [7:0] e;
    rst = r; opc = op; d_in = din;
    model(r, op, din, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    issue(1'b1, 4'h4, 1'b1);
    e = sb.pop_front();
    n_tests++;
    if (io_out !== e) begin n_fail++; $display("FAIL reset_model: got %b want %b", io_out, e); end
    n_tests++;
    if (io_out !== 8'h00) begin n_fail++; $display("FAIL reset_zero: got %b want 00000000", io_out); end
  endtask

  task automatic test_store();
    logic [3:0] ops[9] = '{4'h4, 4'hB, 4'h8, 4'hB, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0};
    logic       ds[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] want[7] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h87, 8'h85, 8'hA1};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, ops[i], ds[i]);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e || io_out !== want[i]) begin
        n_fail++; $display("FAIL store step%0d: got %b want %b", i, io_out, want[i]);
      end
    end
  endtask

  task automatic test_ien();
    logic [3:0] ops[4] = '{4'hA, 4'h1, 4'hA, 4'h1};
    logic       ds[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       rr_w[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ops[i], ds[i]);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e || io_out[0] !== rr_w[i]) begin
        n_fail++; $display("FAIL ien step%0d: got %b want %b (rr %b)", i, io_out, e, rr_w[i]);
      end
    end
  endtask

  task automatic test_skz();
    logic [3:0] ops[9] = '{4'hA, 4'hB, 4'h1, 4'hE, 4'h8, 4'h1, 4'hE, 4'h1, 4'h8};
    logic       ds[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      issue(1'b0, ops[i], ds[i]);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e) begin n_fail++; $display("FAIL skz step%0d: got %b want %b", i, io_out, e); end
      if (i == 4) begin
        n_tests++;
        if (io_out[2] !== 1'b0) begin n_fail++; $display("FAIL skz_discard_wrt: got %b want 0", io_out[2]); end
      end
      if (i == 7) begin
        n_tests++;
        if (io_out[0] !== 1'b0) begin n_fail++; $display("FAIL skz_not_skipped: got rr %b want 0", io_out[0]); end
      end
    end
  endtask

  task automatic test_flags();
    logic [3:0] ops[6] = '{4'h0, 4'hF, 4'hC, 4'hD, 4'h4, 4'h4};
    logic [7:0] want[6] = '{8'h20, 8'h40, 8'h08, 8'h10, 8'h00, 8'h81};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, ops[i], 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e || io_out !== want[i]) begin
        n_fail++; $display("FAIL flags step%0d: got %b want %b", i, io_out, want[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [3:0] ops[9] = '{4'hA, 4'h4, 4'h2, 4'h1, 4'h3, 4'h0, 4'hA, 4'h1, 4'h3};
    logic       ds[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin issue(1'b1, 4'h0, 1'b0); end
      else begin issue(1'b0, ops[i], ds[i]); end
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e) begin n_fail++; $display("FAIL arith step%0d: got %b want %b", i, io_out, e); end
      if (i == 2 || i == 4 || i == 8) begin
        n_tests++;
        if ({io_out[7], io_out[0]} !== ((i == 2) ? 2'b11 : (i == 4) ? 2'b10 : 2'b00)) begin
          n_fail++; $display("FAIL arith_carry step%0d: got car,rr %b%b", i, io_out[7], io_out[0]);
        end
      end
    end
  endtask

  task automatic test_logic_reset();
    logic [3:0] ops[7] = '{4'hA, 4'h4, 4'h5, 4'h5, 4'h7, 4'h6, 4'h0};
    logic       rr_w[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      issue(i == 6, ops[i], 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e || io_out[0] !== rr_w[i]) begin
        n_fail++; $display("FAIL logic step%0d: got %b want %b", i, io_out, e);
      end
    end
    n_tests++;
    if (io_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset: got %b want 00000000", io_out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[9] = '{4'hB, 4'h4, 4'h8, 4'h9, 4'h8, 4'h1, 4'hE, 4'hE, 4'h4};
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      issue(1'b0, ops[i], 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e) begin n_fail++; $display("FAIL b2b step%0d: got %b want %b", i, io_out, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    issue(1'b1, 4'h0, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 29) == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      e = sb.pop_front();
      n_tests++;
      if (io_out !== e) begin n_fail++; $display("FAIL random step%0d: got %b want %b", i, io_out, e); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_store();
    test_ien();
    test_skz();
    test_flags();
    test_arith();
    test_logic_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/user_module_341178296293130834.md
USER_MODULE_341178296293130834 -- requirements
Module: user_module_341178296293130834

Interface
REQ-001 SHALL have no parameters; the 1-bit ICU datapath is fixed.
REQ-002 io_in[0]  input  1  clock; rising edge; one clock; all state updates on this edge only.
REQ-003 io_in[1]  input  1  reset; synchronous, active-high.
REQ-004 io_in[5:2]  input  4  instruction opcode, [5]=MSB.
REQ-005 io_in[6]  input  1  data input bit D_IN.
REQ-006 io_in[7]  input  1  unused; ignored.
REQ-007 io_out[7:0]  output  8  registered status: [0]=RR, [1]=DATA, [2]=WRT, [3]=JMP, [4]=RTN, [5]=FLG0, [6]=FLGF, [7]=CAR.

Function
REQ-008 Opcodes: 0 NOP0, 1 LD, 2 ADD, 3 SUB, 4 ONE, 5 NAND, 6 OR, 7 XOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
REQ-009 Each rising edge executes the opcode on io_in[5:2]; effects are visible on io_out immediately after that edge (one-cycle latency).
REQ-010 Gated data D = D_IN AND IEN; used by LD, ADD, SUB, NAND, OR, XOR.
REQ-011 LD: RR<=D. ONE: RR<=1, CAR<=1. NAND: RR<=~(RR&D). OR: RR<=RR|D. XOR: RR<=RR^D.
REQ-012 ADD: {CAR,RR}<=RR+D+CAR (2-bit sum, carry out to CAR).
REQ-013 SUB: {CAR,RR}<=RR+~D+CAR; CAR=1 means no borrow.
REQ-014 Logic ops and LD leave CAR unchanged.
REQ-015 IEN: IEN<=D_IN (ungated). OEN: OEN<=D_IN.
REQ-016 STO: if OEN=1, DATA<=RR and WRT=1 for that cycle; if OEN=0, DATA holds and WRT=0.
REQ-017 STOC: same as STO with DATA<=~RR.
REQ-018 JMP, RTN, NOP0, NOPF: assert JMP, RTN, FLG0, FLGF respectively for exactly one cycle; no other state change.
REQ-019 WRT, JMP, RTN, FLG0, FLGF SHALL be 0 in every cycle not produced by their instruction (single-cycle pulses; back-to-back instructions give back-to-back pulses).
REQ-020 SKZ: set SKIP if RR=0. RTN: set SKIP unconditionally.
REQ-021 When SKIP=1 the next instruction SHALL be discarded entirely (no register, flag, or pulse change) and SKIP cleared; a discarded SKZ/RTN does not re-arm SKIP.
REQ-022 DATA holds its value between stores.

Reset
REQ-023 With reset high at a clock edge: RR=0, CAR=0, IEN=0, OEN=0, SKIP=0, DATA=0, all pulse outputs 0; the opcode is ignored.
REQ-024 Reset asserted mid-operation SHALL override any instruction and cancel a pending skip.
REQ-025 Before the first reset, outputs are undefined; no power-on behaviour is guaranteed.

Structure
REQ-026 Shared package holds the 16 opcode constants and io_out bit-index constants.
REQ-027 One sub-module, ue_alu (combinational: opcode, RR, D, CAR -> next RR, next CAR), is natural; the sequencer, enable, skip, and output registers stay in the top module.

Verification
REQ-028 Reset; ONE; OEN D_IN=0; STO -> RR=1, WRT=0, DATA=0; OEN 1; STO -> WRT pulse, DATA=1; STOC -> WRT pulse, DATA=0.
REQ-029 Reset; IEN 0; LD D_IN=1 -> RR=0; IEN 1; LD 1 -> RR=1.
REQ-030 IEN 1; LD 0; SKZ; STO -> STO discarded, no WRT; LD 1; SKZ; LD 0 -> RR=0 (not skipped).
REQ-031 NOP0, NOPF, JMP, RTN in sequence -> FLG0, FLGF, JMP, RTN each high one cycle; instruction after RTN discarded.
REQ-032 IEN 1; ONE; ADD 1 -> RR=1, CAR=1; LD 1; SUB 1 with CAR=1 -> RR=0, CAR=1; LD 0; SUB 1 with CAR=0 -> RR=0, CAR=0.
REQ-033 ONE; NAND 1 -> RR=0; NAND 1 -> RR=1; XOR 1 -> RR=0; OR 1 -> RR=1; reset mid-sequence -> all io_out bits 0.
